// File: rtl/demux2_stream.sv
// demux2_stream: 1-to-2 valid/ready stream demultiplexer with a small FIFO per output.
// Ports: clk, reset (sync, active-high), in_valid/in_ready/in_data/in_sel,
//        out0_valid/out0_ready/out0_data, out1_valid/out1_ready/out1_data,
//        count0/count1 (per-output FIFO occupancy).

// demux2_stream_fifo: one output queue of the demux.
// Ports: clk, reset, push/wdata (write side), pop (read side),
//        valid/rdata (head entry), full, count (occupancy).
module demux2_stream_fifo #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [width-1:0]           wdata,
    input  logic                       pop,
    output logic                       valid,
    output logic [width-1:0]           rdata,
    output logic                       full,
    output logic [$clog2(depth+1)-1:0] count
);

    localparam int cw = $clog2(depth + 1);
    localparam int pw = (depth > 1) ? $clog2(depth) : 1;

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;
    logic [cw-1:0]    cnt;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [pw-1:0] nxt(input logic [pw-1:0] p);
        return (p == pw'(depth - 1)) ? '0 : p + pw'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + cw'(1);
            end else if (pop && !push) begin
                cnt <= cnt - cw'(1);
            end
        end
    end

    assign valid = (cnt != '0);
    assign full  = (cnt == cw'(depth));
    assign rdata = mem[rd_ptr];
    assign count = cnt;

endmodule

module demux2_stream #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [width-1:0]           in_data,
    input  logic                       in_sel,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [width-1:0]           out0_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [width-1:0]           out1_data,
    output logic [$clog2(depth+1)-1:0] count0,
    output logic [$clog2(depth+1)-1:0] count1
);

    logic full0;
    logic full1;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Readiness looks only at registered occupancy of the selected
    // queue; a full queue never passes a beat straight through.
    assign in_ready = in_sel ? !full1 : !full0;

    assign push0 = in_valid && in_ready && !in_sel;
    assign push1 = in_valid && in_ready && in_sel;
    assign pop0  = out0_valid && out0_ready;
    assign pop1  = out1_valid && out1_ready;

    demux2_stream_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .wdata (in_data),
        .pop   (pop0),
        .valid (out0_valid),
        .rdata (out0_data),
        .full  (full0),
        .count (count0)
    );

    demux2_stream_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .wdata (in_data),
        .pop   (pop1),
        .valid (out1_valid),
        .rdata (out1_data),
        .full  (full1),
        .count (count1)
    );

endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed plus randomized checks of demux2_stream
// against a queue-based model of the two output FIFOs.
module tb_demux2_stream;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_sel;
    logic          out0_valid;
    logic          out0_ready;
    logic [W-1:0]  out0_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [W-1:0]  out1_data;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] log0[$];
    logic [W-1:0] log1[$];

    demux2_stream #(.width(W), .depth(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .count0     (count0),
        .count1     (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare DUT to model, advance model.
    task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                        input logic r0, input logic r1, input logic rst);
        logic er;
        bit acc, p0, p1;
        in_valid = v; in_sel = s; in_data = d;
        out0_ready = r0; out1_ready = r1; reset = rst;
        #1;
        er = s ? (q1.size() != D) : (q0.size() != D);
        chk("in_ready", in_ready, er);
        chk("count0", count0, q0.size());
        chk("count1", count1, q1.size());
        chk("out0_valid", out0_valid, q0.size() != 0);
        chk("out1_valid", out1_valid, q1.size() != 0);
        if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
        if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
        acc = v && er;
        p0  = (q0.size() != 0) && r0;
        p1  = (q1.size() != 0) && r1;
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (p0) log0.push_back(q0.pop_front());
            if (p1) log1.push_back(q1.pop_front());
            if (acc) begin
                if (s) q1.push_back(d);
                else   q0.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        in_valid = 0; in_sel = 0; in_data = '0;
        out0_ready = 0; out1_ready = 0; reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        // Reset then idle
        chk("rst_valid0", out0_valid, 0);
        chk("rst_valid1", out1_valid, 0);
        chk("rst_count0", count0, 0);
        chk("rst_count1", count1, 0);
        chk("rst_data0", out0_data, 0);
        chk("rst_data1", out1_data, 0);
        in_sel = 0; #1;
        chk("rst_ready_s0", in_ready, 1);
        in_sel = 1; #1;
        chk("rst_ready_s1", in_ready, 1);
        @(negedge clk);

        // Single route
        step(1, 0, 8'hA5, 1, 1, 0);
        in_valid = 0; #1;
        chk("single_data", out0_data, 8'hA5);
        chk("single_valid", out0_valid, 1);
        step(0, 0, 8'h00, 1, 1, 0);
        step(0, 0, 8'h00, 1, 1, 0);
        chk("single_cnt0", count0, 0);
        chk("single_v1", out1_valid, 0);

        // Backpressure fill
        step(1, 0, 8'h11, 0, 1, 0);
        step(1, 0, 8'h22, 0, 1, 0);
        chk("fill_cnt0", count0, 2);
        step(1, 0, 8'h33, 0, 1, 0);
        step(1, 1, 8'h44, 0, 1, 0);
        chk("fill_out1", out1_data, 8'h44);

        // Drain: 0x33 accepted after the first pop
        log0.delete();
        step(1, 0, 8'h33, 1, 1, 0);
        step(1, 0, 8'h33, 1, 1, 0);
        chk("drain_cnt_mid", count0, 1);
        step(0, 0, 8'h00, 1, 1, 0);
        step(0, 0, 8'h00, 1, 1, 0);
        chk("drain_n", log0.size(), 3);
        if (log0.size() == 3) begin
            chk("drain_0", log0[0], 8'h11);
            chk("drain_1", log0[1], 8'h22);
            chk("drain_2", log0[2], 8'h33);
        end

        // Steady stream with wrap
        log0.delete();
        log1.delete();
        for (int i = 0; i < 10; i++) begin
            step(1, i[0], W'(i), 1, 1, 0);
        end
        step(0, 0, 8'h00, 1, 1, 0);
        step(0, 0, 8'h00, 1, 1, 0);
        chk("stream_n0", log0.size(), 5);
        chk("stream_n1", log1.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (log0.size() == 5) chk("stream_o0", log0[i], W'(2 * i));
            if (log1.size() == 5) chk("stream_o1", log1[i], W'(2 * i + 1));
        end

        // Reset mid-operation
        step(1, 0, 8'h51, 0, 0, 0);
        step(1, 0, 8'h52, 0, 0, 0);
        step(1, 1, 8'h61, 0, 0, 0);
        chk("pre_rst_c0", count0, 2);
        chk("pre_rst_c1", count1, 1);
        step(1, 1, 8'h77, 0, 0, 1);
        in_valid = 0; #1;
        chk("mid_rst_c0", count0, 0);
        chk("mid_rst_c1", count1, 0);
        chk("mid_rst_v0", out0_valid, 0);
        chk("mid_rst_v1", out1_valid, 0);
        chk("mid_rst_d1", out1_data, 0);
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom),
                 W'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- 1-to-2 stream demultiplexer. It is the distribution counterpart to the 2-way select mux in the datapath elements library.
- Each beat on a single valid/ready input is routed by a per-beat select bit to one of two valid/ready outputs.
- Each output has its own small FIFO, so a stalled sink does not block beats destined for the other sink once they are already buffered.
- Used to steer results or bus traffic from one producer to two consumers, for example a memory-mapped I/O path versus a data-memory path.

Parameters:
- width, 8, data bits per beat.
- depth, 2, entries per output FIFO. Must be >= 1; need not be a power of two.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block can accept a beat addressed by in_sel.
- in_data  input  width  beat payload.
- in_sel  input  1  destination: 0 routes to out0, 1 routes to out1. Sampled with in_data.
- out0_valid  output  1  out0 FIFO non-empty.
- out0_ready  input  1  sink 0 accepts the head beat.
- out0_data  output  width  out0 FIFO head entry.
- out1_valid  output  1  out1 FIFO non-empty.
- out1_ready  input  1  sink 1 accepts the head beat.
- out1_data  output  width  out1 FIFO head entry.
- count0  output  $clog2(depth+1)  out0 FIFO occupancy.
- count1  output  $clog2(depth+1)  out1 FIFO occupancy.

Behaviour:
- Reset (clk edge with reset=1):
  - Both FIFOs emptied: count0=count1=0, read/write pointers=0.
  - All storage entries cleared to 0, so out0_data=out1_data=0.
  - out0_valid=out1_valid=0.
  - reset dominates every push and pop in that cycle.
  - Reset mid-stream discards all buffered beats. No beat is accepted or delivered on the reset edge.
- Handshakes:
  - Accept occurs when in_valid && in_ready at a clk edge.
  - Delivery on out N occurs when outN_valid && outN_ready.
- in_ready is combinational: in_sel ? (count1 != depth) : (count0 != depth).
  - It depends on registered occupancy only, never on outN_ready. There is no same-cycle pass-through when full.
  - in_ready may be computed while in_valid=0.
- Latency: an accepted beat appears as head of the target FIFO (outN_valid=1, outN_data=beat) on the cycle after acceptance, when that FIFO was empty. Otherwise it appears after all earlier beats routed to the same output.
- Ordering:
  - Per-output FIFO order is strict.
  - No ordering guarantee exists between out0 and out1.
- outN_valid = (countN != 0). outN_data = storage[rd_ptrN]. Both are stable while valid && !ready.
- Push to FIFO N (accepted with in_sel=N):
  - storage[wr_ptrN] <= in_data.
  - wr_ptrN advances, wrapping from depth-1 to 0.
- Pop from FIFO N (delivery):
  - rd_ptrN advances with the same wrap rule.
- Occupancy:
  - Simultaneous push and pop on the same FIFO: countN unchanged, both pointers advance. Allowed at any non-full occupancy. At full, no push occurs because in_ready=0 for that select.
  - Push only: countN+1. Pop only: countN-1.
- Full FIFO N with in_valid=1 and in_sel=N: in_ready=0, the beat is held by the producer, and the other FIFO is unaffected.
- Empty FIFO N with outN_ready=1: no pop, pointers and count unchanged.
- Both outputs may pop in the same cycle as a push to either output.
- in_sel, in_data and out*_ready are don't-care unless the corresponding valid is high.
- Pointer width is max(1, $clog2(depth)). Count saturates logically at depth; no overflow or underflow is permitted by construction.

Test Plan:
- Reset then idle, width=8, depth=2:
  - Required: out0_valid=out1_valid=0, count0=count1=0, out0_data=out1_data=0.
  - Required: in_ready=1 for both in_sel values.
- Single route, sinks ready: send 0xA5 with in_sel=0 at cycle 0.
  - Required: out0_valid=1, out0_data=0xA5 at cycle 1, popped at cycle 1.
  - Required: count0 returns to 0 at cycle 2, out1_valid stays 0.
- Backpressure fill, out0_ready=0: send 0x11, 0x22 with sel=0.
  - Required: count0=2.
  - Required: a third beat 0x33 with sel=0 sees in_ready=0 and stays held.
  - Required: 0x44 with sel=1 is accepted (in_ready=1) and appears on out1 next cycle.
- Drain after fill: raise out0_ready for 3 cycles.
  - Required: out0 delivers 0x11, 0x22, then 0x33 once accepted after the first pop; count0 sequence 2, 1, 1, 0; order preserved.
- Steady stream with pointer wrap: 10 beats 0x00..0x09, alternating sel, both sinks ready every cycle.
  - Required: out0 receives 0x00, 0x02, 0x04, 0x06, 0x08.
  - Required: out1 receives 0x01, 0x03, 0x05, 0x07, 0x09.
  - Required: in_ready stays 1 throughout, and pointers wrap correctly.
- Reset mid-operation: with count0=2 and count1=1, assert reset for one cycle while in_valid=1.
  - Required: next cycle count0=count1=0, both valids 0, and the in-flight beat is not accepted.
